cv32e40s_mpu_resp_queue: RTL and testbench
==========================================

Name: cv32e40s_mpu_resp_queue

Overview:
Parametrised successor to the core's MPU transaction filter. It sits between a core-side request port (LSU or IF) and the OBI bus interface, and supports up to MAX_OUTSTANDING in-flight transactions. It tracks those transactions itself, so no pending-count hint from the core is needed. Transactions that fail MPU checks are held back from the bus and answered in program order, interleaved with real bus responses, with an optional non-blocking mode.

Parameters:
MAX_OUTSTANDING, 2, depth of the in-order tracking queue (>=1, power of 2 not required).
DATA_WIDTH, 32, width of the response read-data field.
ORDERED_ERR, 1, 1: transfers after an MPU error keep flowing and the error is answered in order; 0: all new transfers are blocked until the error response is returned.
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
core_trans_valid_i  input  1  core request valid
core_trans_ready_o  output  1  request accepted (consumed by bus or by MPU)
core_trans_we_i  input  1  request is a write
mpu_err_i  input  1  PMA/PMP check failed for the current request (combinational from checkers)
core_mpu_err_o  output  1  immediate MPU error indication
bus_trans_valid_o  output  1  request forwarded to bus
bus_trans_ready_i  input  1  bus accepts request
bus_resp_valid_i  input  1  bus response valid (cannot be back-pressured)
bus_resp_err_i  input  1  bus error
bus_resp_rdata_i  input  DATA_WIDTH  bus read data
core_resp_valid_o  output  1  response to core (core always ready)
core_resp_status_o  output  2  0 MPU_OK, 1 MPU_RE_FAULT, 2 MPU_WR_FAULT
core_resp_err_o  output  1  bus error of the returned response
core_resp_rdata_o  output  DATA_WIDTH  read data; 0 on MPU fault
outstanding_o  output  CNT_W  number of queued, unreturned transactions

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On reset: all pointers and the counter are 0, all entries are invalid, and every output except the combinational pass-throughs is 0.
- Queue entry fields: {mpu_err, we, resp_done, bus_err, rdata}. There are three pointers: wr (allocate), bus (oldest forwarded entry awaiting a bus response) and rd (head).
- full = (outstanding == MAX_OUTSTANDING).
- block = ORDERED_ERR==0 && any valid entry has mpu_err=1.
- Accept conditions, given core_trans_valid_i && !full && !block:
  - If mpu_err_i: core_trans_ready_o=1 and bus_trans_valid_o=0. Allocate an entry with mpu_err=1, resp_done=1.
  - Else: bus_trans_valid_o=1 and core_trans_ready_o=bus_trans_ready_i. On the handshake, allocate an entry with mpu_err=0, resp_done=0.
- When full or blocked: core_trans_ready_o=0 and bus_trans_valid_o=0.
- core_mpu_err_o = core_trans_valid_i && mpu_err_i, regardless of full or block.
- Bus response handling:
  - bus_resp_valid_i writes bus_err and rdata into the entry at the bus pointer, sets resp_done, and advances the bus pointer past any mpu_err entries.
  - A response with no forwarded entry pending is ignored; the verification assertion fires.
- Output:
  - core_resp_valid_o = head entry valid && resp_done. It is driven purely from flops, so the minimum latency is 1 cycle after acceptance (MPU error) or after bus_resp_valid_i.
  - For an error head: status = we ? 2 : 1, rdata = 0, err = 0.
  - For a bus head: status = 0; err and rdata come from the entry.
  - The head is popped in the same cycle.
- Ordering: responses are returned strictly in acceptance order. An MPU error behind outstanding bus transactions waits until they return.
- Simultaneous push, bus write and pop in one cycle are all legal. outstanding_o = outstanding + push - pop.
- Pointer wrap: pointers wrap modulo MAX_OUTSTANDING; this must hold for non-power-of-2 depths.
- Reset mid-operation discards all entries. Late bus responses after reset are ignored.

Test Plan:
- Single read with mpu_err_i=1 and queue empty -> ready=1 and bus_valid=0 at T; core_resp_valid at T+1 with status=1 and rdata=0; outstanding returns to 0.
- Two reads forwarded, then a write with mpu_err (ORDERED_ERR=1); bus responses rdata 0xA, 0xB arrive at T+3, T+4 -> core sees 0xA, 0xB, then status=2, in that order.
- Same as above with ORDERED_ERR=0 -> a fourth valid request is held at ready=0 until the status=2 response pops, then it is accepted.
- MAX_OUTSTANDING=3, bus_trans_ready_i=1, no responses -> the 4th request sees ready=0 and bus_valid=0; the first response frees one slot the following cycle.
- Bus response arriving in the same cycle that an MPU-error head pops -> error output first, bus response data output next cycle; none lost.
- rst asserted with 2 entries outstanding -> next cycle outstanding_o=0 and core_resp_valid_o=0; a stray bus_resp_valid_i produces no core response.

Source files
------------

// File: rtl/cv32e40s_mpu_resp_queue_if.sv
// Request/response channel of the MPU response queue.
//   core_trans_*      core-side request handshake plus the MPU check result
//   bus_trans_*       request forwarded to the OBI bus
//   bus_resp_*        bus response (never back-pressured)
//   core_resp_*       in-order response to the core (core always ready)
// slave: view of the queue itself; master: view of the surrounding core/bus.
interface cv32e40s_mpu_resp_queue_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  core_trans_valid_i;
  logic                  core_trans_ready_o;
  logic                  core_trans_we_i;
  logic                  mpu_err_i;
  logic                  core_mpu_err_o;
  logic                  bus_trans_valid_o;
  logic                  bus_trans_ready_i;
  logic                  bus_resp_valid_i;
  logic                  bus_resp_err_i;
  logic [DATA_WIDTH-1:0] bus_resp_rdata_i;
  logic                  core_resp_valid_o;
  logic [1:0]            core_resp_status_o;
  logic                  core_resp_err_o;
  logic [DATA_WIDTH-1:0] core_resp_rdata_o;

  modport slave (
    input  core_trans_valid_i, core_trans_we_i, mpu_err_i, bus_trans_ready_i,
           bus_resp_valid_i, bus_resp_err_i, bus_resp_rdata_i,
    output core_trans_ready_o, core_mpu_err_o, bus_trans_valid_o, core_resp_valid_o,
           core_resp_status_o, core_resp_err_o, core_resp_rdata_o
  );

  modport master (
    output core_trans_valid_i, core_trans_we_i, mpu_err_i, bus_trans_ready_i,
           bus_resp_valid_i, bus_resp_err_i, bus_resp_rdata_i,
    input  core_trans_ready_o, core_mpu_err_o, bus_trans_valid_o, core_resp_valid_o,
           core_resp_status_o, core_resp_err_o, core_resp_rdata_o
  );
endinterface

// File: rtl/cv32e40s_mpu_resp_queue.sv
// MPU response queue: filters core requests through the MPU result, forwards clean ones to
// the bus and answers every accepted transaction (bus or MPU fault) strictly in order.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   mpu_if         request/response channel (slave view)
//   outstanding_o  queued, unreturned transactions after this cycle's push/pop
module cv32e40s_mpu_resp_queue #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter bit          ORDERED_ERR     = 1'b1,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  cv32e40s_mpu_resp_queue_if.slave mpu_if,
  output logic [CNT_W-1:0]         outstanding_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  // Per-entry state
  logic [MAX_OUTSTANDING-1:0] valid_q;
  logic [MAX_OUTSTANDING-1:0] mpu_err_q;
  logic [MAX_OUTSTANDING-1:0] we_q;
  logic [MAX_OUTSTANDING-1:0] done_q;
  logic [MAX_OUTSTANDING-1:0] bus_err_q;
  logic [DATA_WIDTH-1:0]      rdata_q [MAX_OUTSTANDING];

  ptr_t             wr_q, rd_q;
  ptr_t             bus_ptr, scan_idx;
  logic             bus_found;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic full, block, can_accept, push, pop, bus_wr;

  // Modulo increment that also holds for non-power-of-2 depths.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

  // Bus pointer: oldest forwarded entry still awaiting its response. Valid entries are
  // contiguous from the head and MPU-error entries are born complete, so the first
  // incomplete entry walking from the head is exactly that one; error entries are skipped.
  always_comb begin
    bus_found = 1'b0;
    bus_ptr   = rd_q;
    scan_idx  = rd_q;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!bus_found && valid_q[scan_idx] && !done_q[scan_idx]) begin
        bus_found = 1'b1;
        bus_ptr   = scan_idx;
      end
      scan_idx = ptr_inc(scan_idx);
    end
  end

  always_comb begin
    full       = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    block      = !ORDERED_ERR && |(valid_q & mpu_err_q);
    can_accept = mpu_if.core_trans_valid_i && !full && !block;

    mpu_if.bus_trans_valid_o  = can_accept && !mpu_if.mpu_err_i;
    mpu_if.core_trans_ready_o = can_accept && (mpu_if.mpu_err_i || mpu_if.bus_trans_ready_i);
    mpu_if.core_mpu_err_o     = mpu_if.core_trans_valid_i && mpu_if.mpu_err_i;

    push   = mpu_if.core_trans_ready_o;
    // Responses with nothing forwarded pending are dropped.
    bus_wr = mpu_if.bus_resp_valid_i && bus_found;
    pop    = valid_q[rd_q] && done_q[rd_q];

    mpu_if.core_resp_valid_o  = pop;
    mpu_if.core_resp_status_o = 2'd0;
    mpu_if.core_resp_err_o    = 1'b0;
    mpu_if.core_resp_rdata_o  = '0;
    if (pop) begin
      if (mpu_err_q[rd_q]) begin
        mpu_if.core_resp_status_o = we_q[rd_q] ? 2'd2 : 2'd1;
      end else begin
        mpu_if.core_resp_err_o   = bus_err_q[rd_q];
        mpu_if.core_resp_rdata_o = rdata_q[rd_q];
      end
    end

    cnt_d         = cnt_q + CNT_W'(push) - CNT_W'(pop);
    outstanding_o = cnt_d;
  end

  // Push (at wr), bus write (incomplete entry) and pop (complete head) never address
  // the same entry, so all three may happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      mpu_err_q <= '0;
      we_q      <= '0;
      done_q    <= '0;
      bus_err_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        rdata_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (bus_wr) begin
        done_q[bus_ptr]    <= 1'b1;
        bus_err_q[bus_ptr] <= mpu_if.bus_resp_err_i;
        rdata_q[bus_ptr]   <= mpu_if.bus_resp_rdata_i;
      end
      if (pop) begin
        valid_q[rd_q] <= 1'b0;
        rd_q          <= ptr_inc(rd_q);
      end
      if (push) begin
        valid_q[wr_q]   <= 1'b1;
        mpu_err_q[wr_q] <= mpu_if.mpu_err_i;
        we_q[wr_q]      <= mpu_if.core_trans_we_i;
        done_q[wr_q]    <= mpu_if.mpu_err_i;
        bus_err_q[wr_q] <= 1'b0;
        rdata_q[wr_q]   <= '0;
        wr_q            <= ptr_inc(wr_q);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cv32e40s_mpu_resp_queue.sv
// Bench for cv32e40s_mpu_resp_queue. Instance a: depth 3, ordered errors.
// Instance b: depth 4, blocking errors. A list-based model per instance is checked
// against every output on every negedge; directed sequences add literal expectations.
module tb_cv32e40s_mpu_resp_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       tv, tmpu, twe, tbrdy, trv, trerr;
  logic [1:0][31:0] trdata;
  logic [1:0]       o_ready, o_mpuerr, o_bval, o_rvalid, o_rerr;
  logic [1:0][1:0]  o_status;
  logic [1:0][31:0] o_rdata;
  logic [1:0][2:0]  o_out;
  logic [1:0]       out_a;
  logic [2:0]       out_b;

  int checks = 0;
  int errors = 0;

  cv32e40s_mpu_resp_queue_if #(.DATA_WIDTH(32)) if_a ();
  cv32e40s_mpu_resp_queue_if #(.DATA_WIDTH(32)) if_b ();

  cv32e40s_mpu_resp_queue #(
    .MAX_OUTSTANDING(3), .DATA_WIDTH(32), .ORDERED_ERR(1'b1)
  ) dut_a (.clk(clk), .rst(rst), .mpu_if(if_a), .outstanding_o(out_a));

  cv32e40s_mpu_resp_queue #(
    .MAX_OUTSTANDING(4), .DATA_WIDTH(32), .ORDERED_ERR(1'b0)
  ) dut_b (.clk(clk), .rst(rst), .mpu_if(if_b), .outstanding_o(out_b));

  assign if_a.core_trans_valid_i = tv[0];
  assign if_a.mpu_err_i          = tmpu[0];
  assign if_a.core_trans_we_i    = twe[0];
  assign if_a.bus_trans_ready_i  = tbrdy[0];
  assign if_a.bus_resp_valid_i   = trv[0];
  assign if_a.bus_resp_err_i     = trerr[0];
  assign if_a.bus_resp_rdata_i   = trdata[0];
  assign if_b.core_trans_valid_i = tv[1];
  assign if_b.mpu_err_i          = tmpu[1];
  assign if_b.core_trans_we_i    = twe[1];
  assign if_b.bus_trans_ready_i  = tbrdy[1];
  assign if_b.bus_resp_valid_i   = trv[1];
  assign if_b.bus_resp_err_i     = trerr[1];
  assign if_b.bus_resp_rdata_i   = trdata[1];

  assign o_ready[0]  = if_a.core_trans_ready_o;
  assign o_mpuerr[0] = if_a.core_mpu_err_o;
  assign o_bval[0]   = if_a.bus_trans_valid_o;
  assign o_rvalid[0] = if_a.core_resp_valid_o;
  assign o_status[0] = if_a.core_resp_status_o;
  assign o_rerr[0]   = if_a.core_resp_err_o;
  assign o_rdata[0]  = if_a.core_resp_rdata_o;
  assign o_out[0]    = {1'b0, out_a};
  assign o_ready[1]  = if_b.core_trans_ready_o;
  assign o_mpuerr[1] = if_b.core_mpu_err_o;
  assign o_bval[1]   = if_b.bus_trans_valid_o;
  assign o_rvalid[1] = if_b.core_resp_valid_o;
  assign o_status[1] = if_b.core_resp_status_o;
  assign o_rerr[1]   = if_b.core_resp_err_o;
  assign o_rdata[1]  = if_b.core_resp_rdata_o;
  assign o_out[1]    = out_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per instance, an ordered list of transactions, index 0 = oldest.
  int   mcnt [2];
  bit   m_err  [2][8];
  bit   m_we   [2][8];
  bit   m_done [2][8];
  bit   m_berr [2][8];
  logic [31:0] m_rdata [2][8];

  task automatic model_step(input int k);
    int cap, e_status, e_out;
    bit ordered, full, block, acc, e_ready, e_bval, e_rvalid, e_rerr, found;
    logic [31:0] e_rdata;
    string p;
    p       = (k == 0) ? "a" : "b";
    cap     = (k == 0) ? 3 : 4;
    ordered = (k == 0);
    full    = (mcnt[k] == cap);
    block   = 1'b0;
    for (int j = 0; j < mcnt[k]; j++) if (m_err[k][j] && !ordered) block = 1'b1;
    acc      = tv[k] && !full && !block;
    e_bval   = acc && !tmpu[k];
    e_ready  = acc && (tmpu[k] || tbrdy[k]);
    e_rvalid = (mcnt[k] > 0) && m_done[k][0];
    e_status = 0;
    e_rerr   = 1'b0;
    e_rdata  = 32'h0;
    if (e_rvalid) begin
      if (m_err[k][0]) e_status = m_we[k][0] ? 2 : 1;
      else begin
        e_rerr  = m_berr[k][0];
        e_rdata = m_rdata[k][0];
      end
    end
    e_out = mcnt[k] + int'(e_ready) - int'(e_rvalid);
    chk({p, ".ready"},      32'(o_ready[k]),  32'(e_ready));
    chk({p, ".bus_valid"},  32'(o_bval[k]),   32'(e_bval));
    chk({p, ".mpu_err"},    32'(o_mpuerr[k]), 32'(tv[k] && tmpu[k]));
    chk({p, ".resp_valid"}, 32'(o_rvalid[k]), 32'(e_rvalid));
    chk({p, ".status"},     32'(o_status[k]), 32'(e_status));
    chk({p, ".resp_err"},   32'(o_rerr[k]),   32'(e_rerr));
    chk({p, ".rdata"},      o_rdata[k],       e_rdata);
    chk({p, ".outstanding"}, 32'(o_out[k]),   32'(e_out));
    // Bus response completes the oldest incomplete transaction, if any.
    found = 1'b0;
    if (trv[k]) begin
      for (int j = 0; j < mcnt[k]; j++) begin
        if (!found && !m_done[k][j]) begin
          found           = 1'b1;
          m_done[k][j]    = 1'b1;
          m_berr[k][j]    = trerr[k];
          m_rdata[k][j]   = trdata[k];
        end
      end
    end
    if (e_rvalid) begin
      for (int j = 0; j < 7; j++) begin
        m_err[k][j]   = m_err[k][j+1];
        m_we[k][j]    = m_we[k][j+1];
        m_done[k][j]  = m_done[k][j+1];
        m_berr[k][j]  = m_berr[k][j+1];
        m_rdata[k][j] = m_rdata[k][j+1];
      end
      mcnt[k]--;
    end
    if (e_ready) begin
      m_err[k][mcnt[k]]   = tmpu[k];
      m_we[k][mcnt[k]]    = twe[k];
      m_done[k][mcnt[k]]  = tmpu[k];
      m_berr[k][mcnt[k]]  = 1'b0;
      m_rdata[k][mcnt[k]] = 32'h0;
      mcnt[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mcnt[0] = 0;
      mcnt[1] = 0;
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Drive one instance's inputs for this cycle, then let combinational outputs settle.
  task automatic drv(input int k, input bit v, input bit mpu, input bit we, input bit brdy,
                     input bit rv, input bit rerr, input logic [31:0] rd);
    tv[k]     = v;
    tmpu[k]   = mpu;
    twe[k]    = we;
    tbrdy[k]  = brdy;
    trv[k]    = rv;
    trerr[k]  = rerr;
    trdata[k] = rd;
    #1;
  endtask

  task automatic idle(input int k);
    drv(k, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    tv = '0; tmpu = '0; twe = '0; tbrdy = '0; trv = '0; trerr = '0; trdata = '0;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    chk("reset.out_a", 32'(o_out[0]), 0);
    chk("reset.out_b", 32'(o_out[1]), 0);
    chk("reset.rvalid_a", 32'(o_rvalid[0]), 0);
    nxt();

    // Single MPU-faulting read on an empty queue.
    drv(0, 1, 1, 0, 0, 0, 0, 0);
    chk("t1.ready", 32'(o_ready[0]), 1);
    chk("t1.bus_valid", 32'(o_bval[0]), 0);
    chk("t1.mpu_err", 32'(o_mpuerr[0]), 1);
    nxt();
    idle(0);
    chk("t1.resp_valid", 32'(o_rvalid[0]), 1);
    chk("t1.status", 32'(o_status[0]), 1);
    chk("t1.rdata", o_rdata[0], 0);
    chk("t1.out", 32'(o_out[0]), 0);
    nxt();

    // Two reads, then a faulting write, ordered mode.
    drv(0, 1, 0, 0, 1, 0, 0, 0); chk("t2.ready0", 32'(o_ready[0]), 1); nxt();
    drv(0, 1, 0, 0, 1, 0, 0, 0); chk("t2.bval1", 32'(o_bval[0]), 1); nxt();
    drv(0, 1, 1, 1, 1, 0, 0, 0); chk("t2.ready2", 32'(o_ready[0]), 1); nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 32'hA); chk("t2.rvalid3", 32'(o_rvalid[0]), 0);
    chk("t2.out3", 32'(o_out[0]), 3); nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 32'hB); chk("t2.rdata_a", o_rdata[0], 32'hA); nxt();
    idle(0); chk("t2.rdata_b", o_rdata[0], 32'hB); nxt();
    chk("t2.status_w", 32'(o_status[0]), 2); chk("t2.out6", 32'(o_out[0]), 0); nxt();
    chk("t2.rvalid7", 32'(o_rvalid[0]), 0);

    // Same on the blocking instance: the fourth request waits for the fault to pop.
    drv(1, 1, 0, 0, 1, 0, 0, 0); nxt();
    drv(1, 1, 0, 0, 1, 0, 0, 0); nxt();
    drv(1, 1, 1, 1, 1, 0, 0, 0); chk("t3.ready2", 32'(o_ready[1]), 1); nxt();
    drv(1, 1, 0, 0, 1, 1, 0, 32'hA); chk("t3.blk3", 32'(o_ready[1]), 0);
    chk("t3.bval3", 32'(o_bval[1]), 0); nxt();
    drv(1, 1, 0, 0, 1, 1, 0, 32'hB); chk("t3.blk4", 32'(o_ready[1]), 0);
    chk("t3.rdata_a", o_rdata[1], 32'hA); nxt();
    drv(1, 1, 0, 0, 1, 0, 0, 0); chk("t3.rdata_b", o_rdata[1], 32'hB); nxt();
    chk("t3.blk6", 32'(o_ready[1]), 0); chk("t3.status_w", 32'(o_status[1]), 2); nxt();
    chk("t3.ready7", 32'(o_ready[1]), 1); chk("t3.bval7", 32'(o_bval[1]), 1); nxt();
    drv(1, 0, 0, 0, 0, 1, 0, 32'hC); chk("t3.out8", 32'(o_out[1]), 1); nxt();
    idle(1); chk("t3.rdata_c", o_rdata[1], 32'hC); nxt();

    // Depth 3 fills up; a response frees a slot once its entry has popped.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 1, 0, 0, 0); chk("t4.fill", 32'(o_ready[0]), 1); nxt();
    end
    drv(0, 1, 0, 0, 1, 1, 0, 32'h11); chk("t4.full_rdy", 32'(o_ready[0]), 0);
    chk("t4.full_bval", 32'(o_bval[0]), 0); chk("t4.out_full", 32'(o_out[0]), 3); nxt();
    drv(0, 1, 0, 0, 1, 0, 0, 0); chk("t4.rdata11", o_rdata[0], 32'h11);
    chk("t4.out_pop", 32'(o_out[0]), 2); nxt();
    drv(0, 1, 0, 0, 1, 0, 0, 0); chk("t4.freed", 32'(o_ready[0]), 1); nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 32'h22); nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 32'h33); chk("t4.rdata22", o_rdata[0], 32'h22); nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 32'h44); chk("t4.rdata33", o_rdata[0], 32'h33); nxt();
    idle(0); chk("t4.rdata44", o_rdata[0], 32'h44); nxt();

    // Bus response and push land in the cycle a faulting head pops.
    drv(0, 1, 0, 0, 1, 0, 0, 0); nxt();
    drv(0, 1, 1, 1, 1, 0, 0, 0); nxt();
    drv(0, 1, 0, 0, 1, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 32'h1); nxt();
    idle(0); chk("t5.rdata1", o_rdata[0], 32'h1); nxt();
    drv(0, 1, 1, 0, 0, 1, 1, 32'h2); chk("t5.status_w", 32'(o_status[0]), 2);
    chk("t5.ready", 32'(o_ready[0]), 1); chk("t5.out", 32'(o_out[0]), 2); nxt();
    idle(0); chk("t5.rdata2", o_rdata[0], 32'h2); chk("t5.berr", 32'(o_rerr[0]), 1); nxt();
    chk("t5.status_r", 32'(o_status[0]), 1); nxt();
    chk("t5.empty", 32'(o_rvalid[0]), 0);

    // Reset with two reads in flight; a late response must not surface.
    drv(0, 1, 0, 0, 1, 0, 0, 0); nxt();
    drv(0, 1, 0, 0, 1, 0, 0, 0); nxt();
    idle(0); chk("t6.out_pre", 32'(o_out[0]), 2); rst = 1'b1; nxt();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 1, 0, 32'h55); chk("t6.out_post", 32'(o_out[0]), 0);
    chk("t6.rvalid_post", 32'(o_rvalid[0]), 0); nxt();
    idle(0); chk("t6.stray", 32'(o_rvalid[0]), 0); nxt();
    chk("t6.stray2", 32'(o_rvalid[0]), 0);
    nxt();
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
